// File: rtl/square_wave_edge_cond.sv
// -----------------------------------------------------------------------------
// square_wave_edge_cond
//
// Input conditioning for the square-wave frequency/duty measurement block.
// For each channel the raw comparator output is synchronised and then
// glitch-filtered: a level change is accepted only after FILT_LEN consecutive
// stable cycles. Accepted changes produce single-cycle rise/fall strobes.
// The block also keeps a free-running timestamp and a per-channel
// signal-present flag that drops after TIMEOUT_CYCLES without an edge.
//
// Ports
//   pll_clk     in   clock, all logic on the rising edge
//   sys_rst_n   in   asynchronous active-low reset
//   wave_in     in   [CH_NUM]        raw asynchronous square inputs
//   filt_en     in   1 = glitch filter active, 0 = bypass
//   glitch_clr  in   single-cycle pulse, clears every glitch counter
//   wave_filt   out  [CH_NUM]        filtered, synchronised level
//   pos_edge    out  [CH_NUM]        strobe on the first cycle wave_filt = 1
//   neg_edge    out  [CH_NUM]        strobe on the first cycle wave_filt = 0
//   ts_now      out  [TS_W]          free-running cycle counter
//   sig_valid   out  [CH_NUM]        accepted edge within last TIMEOUT_CYCLES
//   glitch_cnt  out  [CH_NUM*GL_W]   saturating rejected-pulse counters,
//                                    channel i at [i*GL_W +: GL_W]
// -----------------------------------------------------------------------------
module square_wave_edge_cond #(
  parameter int CH_NUM         = 2,
  parameter int SYNC_STAGES    = 2,
  parameter int FILT_LEN       = 4,
  parameter int TIMEOUT_CYCLES = 200_000_000,
  parameter int TS_W           = 32,
  parameter int GL_W           = 8
) (
  input  logic                   pll_clk,
  input  logic                   sys_rst_n,
  input  logic [CH_NUM-1:0]      wave_in,
  input  logic                   filt_en,
  input  logic                   glitch_clr,
  output logic [CH_NUM-1:0]      wave_filt,
  output logic [CH_NUM-1:0]      pos_edge,
  output logic [CH_NUM-1:0]      neg_edge,
  output logic [TS_W-1:0]        ts_now,
  output logic [CH_NUM-1:0]      sig_valid,
  output logic [CH_NUM*GL_W-1:0] glitch_cnt
);

  // Stability counter only has to reach FILT_LEN-1; timeout counter saturates
  // at TIMEOUT_CYCLES-1.
  localparam int ST_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [ST_W-1:0] ST_LAST = ST_W'(FILT_LEN - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_PRE  = TO_W'(TIMEOUT_CYCLES - 2);
  localparam logic [GL_W-1:0] GL_MAX  = '1;

  // Shared timestamp; consumers difference it modulo 2^TS_W, so plain wrap.
  always_ff @(posedge pll_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ts_now <= '0;
    end else begin
      // NOTE: state is always updated with non-blocking assignments so every
      // flop samples the pre-edge value of every other flop.
      ts_now <= ts_now + 1'b1;
    end
  end

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_lvl;
    logic                   filt_q, filt_d;
    logic [ST_W-1:0]        stab_q, stab_d;
    logic                   glitch_hit;
    logic                   edge_hit;
    logic                   pos_q, neg_q;
    logic [TO_W-1:0]        to_q, to_d;
    logic                   valid_q, valid_d;
    logic [GL_W-1:0]        gl_q, gl_d;

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    // Stability filter: a mismatch must persist for FILT_LEN cycles before it
    // is accepted; a mismatch that disappears early counts as one glitch.
    always_comb begin
      // NOTE: every combinational output gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      filt_d     = filt_q;
      stab_d     = stab_q;
      glitch_hit = 1'b0;
      if (!filt_en) begin
        // Bypass also drops any partial count without calling it a glitch.
        filt_d = sync_lvl;
        stab_d = '0;
      end else if (sync_lvl != filt_q) begin
        if (stab_q == ST_LAST) begin
          filt_d = sync_lvl;
          stab_d = '0;
        end else begin
          stab_d = stab_q + 1'b1;
        end
      end else if (stab_q != '0) begin
        stab_d     = '0;
        glitch_hit = 1'b1;
      end
    end

    assign edge_hit = (filt_d != filt_q);

    // Loss-of-signal timer. An edge on the cycle the timer would expire wins.
    always_comb begin
      to_d    = to_q;
      valid_d = valid_q;
      if (edge_hit) begin
        to_d    = '0;
        valid_d = 1'b1;
      end else if (to_q >= TO_PRE) begin
        to_d    = TO_LAST;
        valid_d = 1'b0;
      end else begin
        to_d = to_q + 1'b1;
      end
    end

    // Clear has priority over a coincident glitch increment.
    always_comb begin
      gl_d = gl_q;
      if (glitch_clr) begin
        gl_d = '0;
      end else if (glitch_hit && (gl_q != GL_MAX)) begin
        gl_d = gl_q + 1'b1;
      end
    end

    always_ff @(posedge pll_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        sync_q  <= '0;
        filt_q  <= 1'b0;
        stab_q  <= '0;
        pos_q   <= 1'b0;
        neg_q   <= 1'b0;
        to_q    <= '0;
        valid_q <= 1'b0;
        gl_q    <= '0;
      end else begin
        sync_q  <= {sync_q[SYNC_STAGES-2:0], wave_in[i]};
        filt_q  <= filt_d;
        stab_q  <= stab_d;
        pos_q   <= edge_hit & filt_d;
        neg_q   <= edge_hit & ~filt_d;
        to_q    <= to_d;
        valid_q <= valid_d;
        gl_q    <= gl_d;
      end
    end

    assign wave_filt[i]                = filt_q;
    assign pos_edge[i]                 = pos_q;
    assign neg_edge[i]                 = neg_q;
    assign sig_valid[i]                = valid_q;
    assign glitch_cnt[i*GL_W +: GL_W]  = gl_q;
  end

endmodule

// File: tb/tb_square_wave_edge_cond.sv
// -----------------------------------------------------------------------------
// tb_square_wave_edge_cond
//
// Directed bench for square_wave_edge_cond (CH_NUM=2, SYNC_STAGES=2,
// FILT_LEN=4, TIMEOUT_CYCLES=1000, TS_W=8, GL_W=8). Stimulus pushes the
// expected strobe (edge number and pos/neg vectors) into a queue; a monitor
// on the falling clock edge pops and compares whenever a strobe appears.
// Inputs change 1 time unit after a rising edge; that edge is edge k.
// -----------------------------------------------------------------------------
module tb_square_wave_edge_cond;

  localparam int CH  = 2;
  localparam int GLW = 8;
  localparam int TSW = 8;
  localparam int TO  = 1000;

  logic              pll_clk    = 1'b0;
  logic              sys_rst_n  = 1'b0;
  logic [CH-1:0]     wave_in    = '0;
  logic              filt_en    = 1'b1;
  logic              glitch_clr = 1'b0;
  logic [CH-1:0]     wave_filt;
  logic [CH-1:0]     pos_edge;
  logic [CH-1:0]     neg_edge;
  logic [TSW-1:0]    ts_now;
  logic [CH-1:0]     sig_valid;
  logic [CH*GLW-1:0] glitch_cnt;

  square_wave_edge_cond #(
    .CH_NUM(CH), .SYNC_STAGES(2), .FILT_LEN(4),
    .TIMEOUT_CYCLES(TO), .TS_W(TSW), .GL_W(GLW)
  ) dut (
    .pll_clk(pll_clk), .sys_rst_n(sys_rst_n), .wave_in(wave_in),
    .filt_en(filt_en), .glitch_clr(glitch_clr), .wave_filt(wave_filt),
    .pos_edge(pos_edge), .neg_edge(neg_edge), .ts_now(ts_now),
    .sig_valid(sig_valid), .glitch_cnt(glitch_cnt)
  );

  always #5 pll_clk = ~pll_clk;

  typedef struct {
    int         edge_no;
    logic [1:0] pos;
    logic [1:0] neg;
  } exp_t;

  exp_t           sb[$];
  int             total  = 0;
  int             bad    = 0;
  int             edge_n = 0;
  logic [TSW-1:0] prev_ts = '0;
  logic [TSW-1:0] cur_ts  = '0;

  always @(posedge pll_clk) edge_n <= edge_n + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Monitor: every strobe cycle must match the head of the scoreboard.
  exp_t mon_e;
  always @(negedge pll_clk) begin
    if ((pos_edge | neg_edge) != '0) begin
      prev_ts = cur_ts;
      cur_ts  = ts_now;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: got pos=%b neg=%b at edge %0d, expected none",
                 pos_edge, neg_edge, edge_n);
      end else begin
        mon_e = sb.pop_front();
        check("strobe_edge_no", edge_n, mon_e.edge_no);
        check("strobe_pos", {30'd0, pos_edge}, {30'd0, mon_e.pos});
        check("strobe_neg", {30'd0, neg_edge}, {30'd0, mon_e.neg});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge pll_clk);
    #1;
  endtask

  // Drive channel ch to v now and expect the matching strobe lat edges later.
  task automatic drive_exp(input int ch, input logic v, input int lat);
    exp_t e;
    logic [1:0] m;
    m           = 2'b01 << ch;
    wave_in[ch] = v;
    e.edge_no   = edge_n + lat;
    e.pos       = v ? m : 2'b00;
    e.neg       = v ? 2'b00 : m;
    sb.push_back(e);
  endtask

  task automatic wait_ts(input logic [TSW-1:0] target, input string name);
    int g;
    g = 0;
    while (ts_now != target && g < 400) begin
      tick(1);
      g++;
    end
    check(name, {24'd0, ts_now}, {24'd0, target});
  endtask

  initial begin
    exp_t       e;
    logic [7:0] d;

    // Reset state
    tick(3);
    check("rst_wave_filt", {30'd0, wave_filt}, 32'd0);
    check("rst_strobes", {28'd0, pos_edge, neg_edge}, 32'd0);
    check("rst_ts_now", {24'd0, ts_now}, 32'd0);
    check("rst_sig_valid", {30'd0, sig_valid}, 32'd0);
    check("rst_glitch_cnt", {16'd0, glitch_cnt}, 32'd0);
    sys_rst_n = 1'b1;

    // 1: filtered rising edge on ch0 lands at edge k+6
    drive_exp(0, 1'b1, 6);
    tick(5);
    check("t1_filt_before", {30'd0, wave_filt}, 32'd0);
    tick(1);
    check("t1_filt_after", {30'd0, wave_filt}, 32'd1);
    check("t1_sig_valid0", {31'd0, sig_valid[0]}, 32'd1);
    check("t1_glitch0", {24'd0, glitch_cnt[7:0]}, 32'd0);
    tick(2);

    // 2: 3-cycle pulses on ch1 are rejected and counted, saturating at 255
    for (int p = 0; p < 300; p++) begin
      wave_in[1] = 1'b1;
      tick(3);
      wave_in[1] = 1'b0;
      tick(4);
      if (p == 0) begin
        check("t2_filt1_low", {31'd0, wave_filt[1]}, 32'd0);
        check("t2_glitch1_one", {24'd0, glitch_cnt[15:8]}, 32'd1);
        check("t2_glitch0_zero", {24'd0, glitch_cnt[7:0]}, 32'd0);
      end
      if (p == 9) check("t2_glitch1_ten", {24'd0, glitch_cnt[15:8]}, 32'd10);
    end
    tick(3);
    check("t2_glitch1_sat", {24'd0, glitch_cnt[15:8]}, 32'd255);
    glitch_clr = 1'b1;
    tick(1);
    glitch_clr = 1'b0;
    check("t2_glitch1_clr", {24'd0, glitch_cnt[15:8]}, 32'd0);
    // glitch_clr coinciding with a glitch increment (edge k+6): clear wins
    wave_in[1] = 1'b1;
    tick(3);
    wave_in[1] = 1'b0;
    tick(2);
    glitch_clr = 1'b1;
    tick(1);
    glitch_clr = 1'b0;
    check("t2_clr_wins", {24'd0, glitch_cnt[15:8]}, 32'd0);
    tick(3);

    // 3: bypass, 3-cycle pulse on ch1 passes through with latency 3
    filt_en = 1'b0;
    tick(2);
    drive_exp(1, 1'b1, 3);
    tick(2);
    check("t3_filt1_k2", {31'd0, wave_filt[1]}, 32'd0);
    tick(1);
    check("t3_filt1_k3", {31'd0, wave_filt[1]}, 32'd1);
    drive_exp(1, 1'b0, 3);
    tick(2);
    check("t3_filt1_k5", {31'd0, wave_filt[1]}, 32'd1);
    tick(1);
    check("t3_filt1_k6", {31'd0, wave_filt[1]}, 32'd0);
    check("t3_glitch1", {24'd0, glitch_cnt[15:8]}, 32'd0);
    filt_en = 1'b1;
    tick(2);

    // 4: 20-cycle square on ch0, then timeout after 999 cycles
    check("t4_valid0_stale", {31'd0, sig_valid[0]}, 32'd0);
    for (int t = 0; t < 6; t++) begin
      drive_exp(0, ~wave_in[0], 6);
      if (t == 0) begin
        tick(5);
        check("t4_valid0_pre", {31'd0, sig_valid[0]}, 32'd0);
        tick(1);
        check("t4_valid0_first", {31'd0, sig_valid[0]}, 32'd1);
        tick(4);
      end else begin
        tick(10);
      end
    end
    tick(994);
    check("t4_valid0_998", {31'd0, sig_valid[0]}, 32'd1);
    tick(1);
    check("t4_valid0_999", {31'd0, sig_valid[0]}, 32'd0);
    // An edge landing exactly on cycle 999 keeps the channel valid
    drive_exp(0, ~wave_in[0], 6);
    tick(6);
    check("t4_valid0_rearm", {31'd0, sig_valid[0]}, 32'd1);
    tick(993);
    drive_exp(0, ~wave_in[0], 6);
    tick(5);
    check("t4_edge_998", {31'd0, sig_valid[0]}, 32'd1);
    tick(1);
    check("t4_edge_999", {31'd0, sig_valid[0]}, 32'd1);
    tick(1);
    check("t4_edge_1000", {31'd0, sig_valid[0]}, 32'd1);

    // 5: timestamp wrap and modulo difference across the wrap
    filt_en = 1'b0;
    tick(1);
    wait_ts(8'd255, "t5_ts_255");
    tick(1);
    check("t5_ts_wrap", {24'd0, ts_now}, 32'd0);
    wait_ts(8'd247, "t5_ts_247");
    drive_exp(1, 1'b1, 3);
    tick(10);
    drive_exp(1, 1'b0, 3);
    tick(4);
    d = cur_ts - prev_ts;
    check("t5_first_ts", {24'd0, prev_ts}, 32'd250);
    check("t5_second_ts", {24'd0, cur_ts}, 32'd4);
    check("t5_ts_diff", {24'd0, d}, 32'd10);
    filt_en = 1'b1;
    tick(2);

    // 6: reset mid-filter on ch0 and with ch1 high
    drive_exp(1, 1'b1, 6);
    tick(8);
    check("t6_filt1_high", {31'd0, wave_filt[1]}, 32'd1);
    wave_in[0] = ~wave_in[0];
    tick(4);
    sys_rst_n = 1'b0;
    #1;
    check("t6_rst_wave_filt", {30'd0, wave_filt}, 32'd0);
    check("t6_rst_strobes", {28'd0, pos_edge, neg_edge}, 32'd0);
    check("t6_rst_ts", {24'd0, ts_now}, 32'd0);
    check("t6_rst_valid", {30'd0, sig_valid}, 32'd0);
    wave_in = 2'b11;
    tick(3);
    sys_rst_n = 1'b1;
    e.edge_no = edge_n + 6;
    e.pos     = 2'b11;
    e.neg     = 2'b00;
    sb.push_back(e);
    tick(5);
    check("t6_filt_pre", {30'd0, wave_filt}, 32'd0);
    tick(1);
    check("t6_filt_post", {30'd0, wave_filt}, 32'd3);
    tick(4);

    check("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/square_wave_edge_cond.md
Name: square_wave_edge_cond

Overview:
Input conditioning stage that sits directly upstream of the square-wave frequency/duty measurement block, in the 200 MHz pll_clk domain.
- Per channel: synchronises the raw comparator outputs, rejects glitches with a programmable stability filter, and emits single-cycle rising/falling edge strobes.
- Also provides a shared free-running timestamp and a per-channel signal-present flag.
- The measurement block consumes pos_edge/neg_edge plus ts_now to take start/end timestamps.

Parameters:
CH_NUM, 2, number of input channels
SYNC_STAGES, 2, synchroniser depth (>=2)
FILT_LEN, 4, consecutive stable cycles required to accept a level change (>=1)
TIMEOUT_CYCLES, 200_000_000, cycles without an accepted edge before the channel is flagged lost (1 s at 200 MHz)
TS_W, 32, timestamp width
GL_W, 8, glitch counter width

Ports:
pll_clk  in  1  200 MHz clock; all logic on rising edge
sys_rst_n  in  1  asynchronous, active-low reset
wave_in  in  CH_NUM  raw asynchronous square inputs
filt_en  in  1  1 = glitch filter active; 0 = bypass
glitch_clr  in  1  single-cycle pulse, clears all glitch counters
wave_filt  out  CH_NUM  filtered, synchronised level
pos_edge  out  CH_NUM  1-cycle strobe, first cycle wave_filt[i]=1
neg_edge  out  CH_NUM  1-cycle strobe, first cycle wave_filt[i]=0
ts_now  out  TS_W  free-running cycle counter
sig_valid  out  CH_NUM  1 = accepted edge within last TIMEOUT_CYCLES
glitch_cnt  out  CH_NUM*GL_W  packed per-channel rejected-pulse counters; ch i at [i*GL_W +: GL_W]

Behaviour:
- Reset (async assert, sync release): all sync flops, wave_filt, pos_edge, neg_edge, ts_now, sig_valid, glitch_cnt, stab_cnt and timeout counters go to 0.
- Synchroniser: SYNC_STAGES flops per channel. sync[i] is the last stage.
- Filter, filt_en=1, per channel:
  - mismatch = sync[i] != wave_filt[i].
  - If mismatch and stab_cnt < FILT_LEN-1: stab_cnt++.
  - If mismatch and stab_cnt == FILT_LEN-1: wave_filt[i] <= sync[i], stab_cnt <= 0.
  - If no mismatch and stab_cnt != 0: stab_cnt <= 0 and glitch_cnt[i]++ (saturate at 2^GL_W-1).
  - Resulting latency: a new level stable at wave_in for >= SYNC_STAGES+FILT_LEN cycles appears on wave_filt exactly SYNC_STAGES+FILT_LEN edges after the first sampling edge.
  - Pulses shorter than FILT_LEN cycles (post-sync) never reach wave_filt.
- Filter, filt_en=0: wave_filt[i] <= sync[i] every cycle (latency SYNC_STAGES+1). stab_cnt is held at 0 and no glitches are counted.
- filt_en change takes effect on the next cycle. Switching 1->0 discards any partial stab_cnt without counting a glitch.
- Edge strobes: registered in the same cycle as the wave_filt update.
  - pos_edge[i]=1 iff wave_filt[i] goes 0->1 at that edge; neg_edge likewise for 1->0.
  - Never both high on one channel; high for exactly 1 cycle.
  - There is no edge on reset release (wave_filt starts 0; an input already high yields pos_edge after the latency).
- ts_now: increments every cycle and wraps 2^TS_W-1 -> 0. Consumers difference timestamps with unsigned modulo-2^TS_W subtraction.
- Timeout, per channel, counter of width clog2(TIMEOUT_CYCLES):
  - Cleared on any pos_edge/neg_edge; otherwise increments, saturating at TIMEOUT_CYCLES-1.
  - sig_valid[i] <= 1 on any edge strobe; sig_valid[i] <= 0 when the counter reaches TIMEOUT_CYCLES-1.
  - If an edge occurs in the same cycle as the timeout is reached, the edge wins: counter cleared, sig_valid=1.
- glitch_clr: clears all glitch_cnt next cycle. If a glitch increment coincides with glitch_clr, the clear wins (result 0).
- Channels are fully independent. Simultaneous edges on different channels are all reported in the same cycle.
- Reset mid-operation: all state returns to reset values immediately. No strobe is generated by reset itself.

Test Plan:
1. Defaults, filt_en=1; wave_in[0] 0->1 at sampling edge k, held -> wave_filt[0]=1 and pos_edge[0]=1 for one cycle at edge k+6; glitch_cnt[0]=0.
2. filt_en=1; 3-cycle high pulse on wave_in[1] -> wave_filt[1] stays 0, no strobes, glitch_cnt[1]=1; repeat 300 times -> saturates at 255; glitch_clr -> 0.
3. filt_en=0; same 3-cycle pulse -> wave_filt[1] high 3 cycles starting edge k+3; one pos_edge and one neg_edge; glitch_cnt unchanged.
4. TIMEOUT_CYCLES=1000; 10 MHz square (20 cycles/period) on ch0 -> sig_valid[0]=1 after first edge; stop input -> sig_valid[0]=0 exactly 999 cycles after last strobe; an edge landing on cycle 999 keeps sig_valid=1.
5. TS_W=8; run 300 cycles -> ts_now wraps 255->0 at cycle 256; edge timestamps 250 and 4 give unsigned difference 10.
6. Assert sys_rst_n low mid-filter (stab_cnt=2) and mid-high level -> all outputs 0 immediately, no strobe; after release with wave_in high -> pos_edge after 6 cycles.
